// File: rtl/cereal_rx.sv
// cereal_rx: 8N1 serial receiver that assembles CR/LF-terminated words in a 64x8 buffer.
// Define RX_PARITY_EN to receive 8E1 frames (even parity bit after the data bits).
module cereal_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int MAX_LEN      = 63
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       par_err,
  output logic       word_done,
  output logic [5:0] word_len,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [5:0] MAXL = 6'(MAX_LEN);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } state_e;
`endif

  state_e state_q, state_d;

  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          pend_q, pend_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          word_done_q, word_done_d;
  logic [5:0]    word_len_q, word_len_d;
  logic [5:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          wr_en;
  logic [5:0]    next_cnt;
  logic          is_eol;

  logic [7:0]    mem_q [64];

`ifdef RX_PARITY_EN
  logic          par_ok_q, par_ok_d;
  logic          par_err_q, par_err_d;
`endif

  // Frame decoder: start-bit check, mid-bit sampling, stop-bit validation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    pend_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
    par_ok_d    = par_ok_q;
    par_err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL) begin
          cnt_d    = '0;
          par_ok_d = (rx_s_q == ^shift_q);
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d       = '0;
          frame_err_d = !rx_s_q;
          state_d     = rx_s_q ? IDLE : WAIT_IDLE;
`ifdef RX_PARITY_EN
          par_err_d   = !par_ok_q;
          pend_d      = rx_s_q && par_ok_q;
`else
          pend_d      = rx_s_q;
`endif
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word assembly on each delivered byte; CR/LF closes a non-empty word
  always_comb begin
    byte_valid_d = pend_q;
    byte_data_d  = pend_q ? shift_q : byte_data_q;
    word_done_d  = 1'b0;
    word_len_d   = word_len_q;
    wr_ptr_d     = wr_ptr_q;
    wr_en        = 1'b0;
    next_cnt     = wr_ptr_q + 6'd1;
    is_eol       = (shift_q == 8'h0D) || (shift_q == 8'h0A);
    rd_data_d    = mem_q[rd_addr];
    if (pend_q) begin
      if (is_eol) begin
        if (wr_ptr_q != 6'd0) begin
          word_done_d = 1'b1;
          word_len_d  = wr_ptr_q;
          wr_ptr_d    = 6'd0;
        end
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = next_cnt;
        if (next_cnt == MAXL) begin
          word_done_d = 1'b1;
          word_len_d  = MAXL;
          wr_ptr_d    = 6'd0;
        end
      end
    end
  end

  // State, synchronizer and output registers
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      pend_q       <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      word_done_q  <= 1'b0;
      word_len_q   <= 6'd0;
      wr_ptr_q     <= 6'd0;
      rd_data_q    <= 8'h00;
`ifdef RX_PARITY_EN
      par_ok_q     <= 1'b1;
      par_err_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      word_done_q  <= word_done_d;
      word_len_q   <= word_len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_data_q    <= rd_data_d;
`ifdef RX_PARITY_EN
      par_ok_q     <= par_ok_d;
      par_err_q    <= par_err_d;
`endif
    end
  end

  // Word buffer storage, not cleared by reset
  always_ff @(posedge sysclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_data    = rd_data_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign word_done  = word_done_q;
  assign word_len   = word_len_q;
  assign busy       = (state_q != IDLE);
`ifdef RX_PARITY_EN
  assign par_err    = par_err_q;
`else
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cereal_rx.sv
// tb_cereal_rx: directed vectors and corner sequences for cereal_rx.
// Uses CLKS_PER_BIT=16; parity cases build only with RX_PARITY_EN.
module tb_cereal_rx;

  localparam int CPB = 16;
`ifdef RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       sysclk;
  logic       rst_n;
  logic       rx;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic       par_err;
  logic       word_done;
  logic [5:0] word_len;
  logic       busy;

  cereal_rx #(
    .CLKS_PER_BIT(CPB),
    .MAX_LEN(63)
  ) dut (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .rx(rx),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .frame_err(frame_err),
    .par_err(par_err),
    .word_done(word_done),
    .word_len(word_len),
    .busy(busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int bv_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int wd_cnt = 0;
  int bv_cyc = 0;

  // Pulse monitors, sampled on the falling edge
  always @(negedge sysclk) begin
    if (byte_valid) begin
      bv_cnt <= bv_cnt + 1;
      bv_cyc <= cyc;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (par_err)   pe_cnt <= pe_cnt + 1;
    if (word_done) wd_cnt <= wd_cnt + 1;
  end

  int nchecks = 0;
  int nerrors = 0;
  int fall_cyc = 0;

  task automatic check(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Drive one frame; the line is left at the stop-bit level
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic pflip);
    @(negedge sysclk);
    rx = 1'b0;
    fall_cyc = cyc;
    wait_neg(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_neg(CPB);
    end
`ifdef RX_PARITY_EN
    rx = (^b) ^ pflip;
    wait_neg(CPB);
`else
    if (pflip) rx = 1'b1;
`endif
    rx = stop;
    wait_neg(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0);
    wait_neg(CPB);
  endtask

  task automatic read_chk(input string nm, input logic [5:0] a,
                          input int exp);
    @(negedge sysclk);
    rd_addr = a;
    @(negedge sysclk);
    check(nm, int'(rd_data), exp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_bv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[5];

  int b0, f0, w0, p0, lat;

  initial begin
    vecs[0] = '{8'h41, 1'b1, 1, 0, 8'h41};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[4] = '{8'h5A, 1'b0, 0, 1, 8'hA5};

    rx = 1'b1;
    rd_addr = 6'd0;
    rst_n = 1'b0;
    wait_neg(4);
    check("rst_busy", int'(busy), 0);
    check("rst_bv", int'(byte_valid), 0);
    check("rst_byte", int'(byte_data), 0);
    check("rst_wlen", int'(word_len), 0);
    check("rst_rd", int'(rd_data), 0);
    rst_n = 1'b1;
    wait_neg(8);

    // Table-driven single frames
    for (int i = 0; i < 5; i++) begin
      b0 = bv_cnt;
      f0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      if (i == 0) begin
        lat = bv_cyc - fall_cyc;
        nchecks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          nerrors++;
          $display("FAIL latency: got %0d expected %0d+-1", lat, LAT);
        end
      end
      if (!vecs[i].stop) begin
        wait_neg(2 * CPB);
        rx = 1'b1;
      end
      wait_neg(2 * CPB);
      check($sformatf("v%0d_bv", i), bv_cnt - b0, vecs[i].exp_bv);
      check($sformatf("v%0d_fe", i), fe_cnt - f0, vecs[i].exp_fe);
      check($sformatf("v%0d_byte", i), int'(byte_data),
            int'(vecs[i].exp_byte));
    end

    // Flush: four good bytes form a word, the errored one is absent
    w0 = wd_cnt;
    send_byte(8'h0D);
    check("tbl_wd", wd_cnt - w0, 1);
    check("tbl_wlen", int'(word_len), 4);
    read_chk("tbl_rd0", 6'd0, 8'h41);
    read_chk("tbl_rd1", 6'd1, 8'h00);
    read_chk("tbl_rd2", 6'd2, 8'hFF);
    read_chk("tbl_rd3", 6'd3, 8'hA5);

    // "HI\r" then a lone "\n"
    w0 = wd_cnt;
    send_byte(8'h48);
    send_byte(8'h49);
    send_byte(8'h0D);
    check("hi_wd", wd_cnt - w0, 1);
    check("hi_wlen", int'(word_len), 2);
    read_chk("hi_rd0", 6'd0, 8'h48);
    read_chk("hi_rd1", 6'd1, 8'h49);
    send_byte(8'h0A);
    check("lf_nowd", wd_cnt - w0, 1);

    // Framing error followed by a long break, then recovery
    b0 = bv_cnt;
    f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_neg(40 * CPB);
    check("brk_busy", int'(busy), 1);
    rx = 1'b1;
    wait_neg(2 * CPB);
    check("brk_idle", int'(busy), 0);
    check("brk_fe", fe_cnt - f0, 1);
    check("brk_nobv", bv_cnt - b0, 0);
    send_byte(8'h42);
    check("brk_bv", bv_cnt - b0, 1);
    check("brk_byte", int'(byte_data), 8'h42);

    // Short glitch is rejected
    b0 = bv_cnt;
    f0 = fe_cnt;
    @(negedge sysclk);
    rx = 1'b0;
    wait_neg(4);
    rx = 1'b1;
    wait_neg(3 * CPB);
    check("gl_bv", bv_cnt - b0, 0);
    check("gl_fe", fe_cnt - f0, 0);
    check("gl_busy", int'(busy), 0);

    // Reset in the middle of data bit 3
    @(negedge sysclk);
    rx = 1'b0;
    wait_neg(CPB + 3 * CPB + 8);
    rst_n = 1'b0;
    wait_neg(2);
    check("mr_busy", int'(busy), 0);
    check("mr_byte", int'(byte_data), 0);
    check("mr_wlen", int'(word_len), 0);
    check("mr_rd", int'(rd_data), 0);
    rx = 1'b1;
    wait_neg(4);
    rst_n = 1'b1;
    wait_neg(2 * CPB);
    b0 = bv_cnt;
    send_byte(8'h33);
    check("mr_bv", bv_cnt - b0, 1);
    check("mr_data", int'(byte_data), 8'h33);
    w0 = wd_cnt;
    send_byte(8'h0D);
    check("mr_wlen1", int'(word_len), 1);
    check("mr_wd", wd_cnt - w0, 1);
    read_chk("mr_rd0", 6'd0, 8'h33);

    // 63 characters auto-complete a word
    w0 = wd_cnt;
    for (int i = 0; i < 62; i++) send_byte(8'h61);
    check("max_62", wd_cnt - w0, 0);
    send_byte(8'h61);
    check("max_wd", wd_cnt - w0, 1);
    check("max_wlen", int'(word_len), 63);
    read_chk("max_rd62", 6'd62, 8'h61);
    send_byte(8'h0D);
    check("max_cr", wd_cnt - w0, 1);

`ifdef RX_PARITY_EN
    // Parity: good byte stored, bad byte dropped without moving wr_ptr
    b0 = bv_cnt;
    p0 = pe_cnt;
    w0 = wd_cnt;
    send_byte(8'h41);
    check("par_ok_bv", bv_cnt - b0, 1);
    send_frame(8'h41, 1'b1, 1'b1);
    wait_neg(CPB);
    check("par_err", pe_cnt - p0, 1);
    check("par_nobv", bv_cnt - b0, 1);
    send_byte(8'h0D);
    check("par_wlen", int'(word_len), 1);
    check("par_wd", wd_cnt - w0, 1);
`else
    p0 = pe_cnt;
    send_frame(8'h41, 1'b1, 1'b1);
    wait_neg(CPB);
    check("par_off", pe_cnt - p0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
